io_port_responder: RTL and testbench

- CPU-side responder for the processor's byte-wide I/O bus (io_sel / io_data / io_reading / io_output).
- Decodes CPU writes (io_output strobes) into a TX byte FIFO drained by an external consumer.
- Answers CPU reads (io_reading) from an RX byte FIFO filled by an external producer, or from a status register.
- Sits between the cpu instance and board-level peripherals or bench models.

---
 rtl/io_port_responder.sv | 111 +++++++++++
 tb/tb_io_port_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// Byte-wide CPU I/O port responder: CPU writes feed a TX FIFO for a consumer,
// CPU reads return RX FIFO bytes from a producer or a status byte.
module io_port_responder #(
  parameter int DEPTH    = 8,
  parameter int SEL_W    = 4,
  parameter int DATA_SEL = 0,
  parameter int STAT_SEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] io_sel,
  input  logic [7:0]       io_wdata,
  input  logic             io_output,
  input  logic             io_reading,
  output logic [7:0]       io_rdata,
  output logic             io_rvalid,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             tx_overflow,
  output logic             rx_underflow
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic              wr_q, rd_q, wr_evt, rd_evt;
  logic              sel_data, sel_stat;
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              ovf_set, unf_set, stat_rd;
  logic [DATA_W-1:0] rd_val;

  assign wr_evt   = io_output & ~wr_q;
  assign rd_evt   = io_reading & ~rd_q;
  assign sel_data = (io_sel == SEL_W'(DATA_SEL));
  assign sel_stat = (io_sel == SEL_W'(STAT_SEL));

  assign tx_full  = (tx_cnt == CNT_W'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CNT_W'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  // Full is judged before any same-cycle pop, so a push at full is always dropped.
  assign tx_push = wr_evt & sel_data & ~tx_full;
  assign ovf_set = wr_evt & sel_data & tx_full;
  assign tx_pop  = ~tx_empty & out_ready;
  assign rx_push = in_valid & ~rx_full;
  assign rx_pop  = rd_evt & sel_data & ~rx_empty;
  assign unf_set = rd_evt & sel_data & rx_empty;
  assign stat_rd = rd_evt & sel_stat;

  assign in_ready  = ~rx_full;
  assign out_valid = ~tx_empty;
  assign out_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr];

  always_comb begin
    rd_val = '0;
    if (sel_data && !rx_empty)
      rd_val = rx_mem[rx_rd_ptr];
    else if (sel_stat)
      rd_val = {3'b000, rx_underflow, tx_overflow, rx_full, tx_full, ~rx_empty};
  end

  // Control: edge detect, pointers, counts, sticky flags, read response
  always_ff @(posedge clk) begin
    if (rst) begin
      // Tracking the strobes through reset keeps a held strobe from looking like an edge.
      wr_q         <= io_output;
      rd_q         <= io_reading;
      tx_wr_ptr    <= '0;
      tx_rd_ptr    <= '0;
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      io_rvalid    <= 1'b0;
      io_rdata     <= '0;
    end else begin
      wr_q <= io_output;
      rd_q <= io_reading;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      tx_cnt       <= tx_cnt + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_cnt       <= rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop);
      tx_overflow  <= ovf_set | (tx_overflow & ~stat_rd);
      rx_underflow <= unf_set | (rx_underflow & ~stat_rd);
      io_rvalid    <= rd_evt;
      if (rd_evt) io_rdata <= rd_val;
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= io_wdata;
    if (rx_push) rx_mem[rx_wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Randomized scoreboard bench for io_port_responder against a queue-based model.
module tb_io_port_responder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] io_sel;
  logic [7:0] io_wdata;
  logic       io_output, io_reading;
  logic [7:0] io_rdata;
  logic       io_rvalid;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic       tx_overflow, rx_underflow;

  io_port_responder #(.DEPTH(DEPTH), .SEL_W(4), .DATA_SEL(0), .STAT_SEL(1)) dut (
    .clk(clk), .rst(rst), .io_sel(io_sel), .io_wdata(io_wdata),
    .io_output(io_output), .io_reading(io_reading), .io_rdata(io_rdata),
    .io_rvalid(io_rvalid), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .tx_overflow(tx_overflow), .rx_underflow(rx_underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] txq[$], rxq[$], exp_rd[$], exp_tx[$];
  logic       m_ovf, m_unf, m_rvalid, prev_out, prev_rd, seen_rst;
  logic [7:0] m_rdata;
  // State visible between edges, compared by the monitor
  logic       s_rvalid, s_in_ready, s_out_valid, s_ovf, s_unf, snap_ok;
  logic [7:0] s_rdata, s_out_data;

  int vectors, miscompares;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic wr, rd, stat, ovf_set, unf_set, tx_was_full, rx_was_full;
    logic [7:0] v;
    snap_ok     = seen_rst;
    s_rvalid    = m_rvalid;
    s_rdata     = m_rdata;
    s_in_ready  = (rxq.size() < DEPTH);
    s_out_valid = (txq.size() > 0);
    s_out_data  = (txq.size() > 0) ? txq[0] : 8'h00;
    s_ovf       = m_ovf;
    s_unf       = m_unf;
    if (rst) begin
      txq.delete(); rxq.delete();
      m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = 0;
      seen_rst = 1;
    end else begin
      wr = io_output && !prev_out;
      rd = io_reading && !prev_rd;
      stat = 0; ovf_set = 0; unf_set = 0;
      tx_was_full = (txq.size() == DEPTH);
      rx_was_full = (rxq.size() == DEPTH);
      if (rd) begin
        v = 8'h00;
        if (io_sel == 0) begin
          if (rxq.size() > 0) v = rxq.pop_front();
          else unf_set = 1;
        end else if (io_sel == 1) begin
          v = {3'b000, m_unf, m_ovf, rx_was_full, tx_was_full, rxq.size() != 0};
          stat = 1;
        end
        exp_rd.push_back(v);
        m_rdata = v;
      end
      m_rvalid = rd;
      if (txq.size() > 0 && out_ready) exp_tx.push_back(txq.pop_front());
      if (wr && io_sel == 0) begin
        if (tx_was_full) ovf_set = 1;
        else txq.push_back(io_wdata);
      end
      if (in_valid && !rx_was_full) rxq.push_back(in_data);
      m_ovf = ovf_set | (m_ovf & !stat);
      m_unf = unf_set | (m_unf & !stat);
    end
    prev_out = io_output;
    prev_rd  = io_reading;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (snap_ok) begin
        check("io_rvalid", io_rvalid, s_rvalid);
        check("io_rdata_hold", io_rdata, s_rdata);
        check("in_ready", in_ready, s_in_ready);
        check("out_valid", out_valid, s_out_valid);
        check("out_data_head", out_data, s_out_data);
        check("tx_overflow", tx_overflow, s_ovf);
        check("rx_underflow", rx_underflow, s_unf);
        if (io_rvalid) begin
          if (exp_rd.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL rd_scoreboard: read response %h with none expected", io_rdata);
          end else check("rd_data", io_rdata, exp_rd.pop_front());
        end
        if (out_valid && out_ready && !rst) begin
          if (exp_tx.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL tx_scoreboard: consumer took %h with none expected", out_data);
          end else check("tx_data", out_data, exp_tx.pop_front());
        end
      end
    end
  endtask

  task automatic wr_byte(input logic [3:0] sel, input logic [7:0] d);
    io_sel = sel; io_wdata = d; io_output = 1; cycle();
    io_output = 0; cycle();
  endtask

  task automatic rd_port(input logic [3:0] sel);
    io_sel = sel; io_reading = 1; cycle();
    io_reading = 0; cycle();
  endtask

  initial begin
    int pushed;
    logic accepted;
    vectors = 0; miscompares = 0;
    m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = 0;
    prev_out = 0; prev_rd = 0; seen_rst = 0; snap_ok = 0;
    rst = 1; io_sel = 0; io_wdata = 0; io_output = 0; io_reading = 0;
    in_data = 0; in_valid = 0; out_ready = 0;
    fork monitor(); join_none
    cycle(); cycle();
    rst = 0; cycle();
    check("rst_io_rdata", io_rdata, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);

    // Write path
    wr_byte(0, 8'h41); wr_byte(0, 8'h42);
    check("wp_head1", out_data, 8'h41);
    out_ready = 1; cycle(); out_ready = 0;
    check("wp_head2", out_data, 8'h42);
    out_ready = 1; cycle(); out_ready = 0;
    check("wp_empty", out_valid, 1'b0);

    // Long strobe yields one entry
    io_wdata = 8'h55; io_output = 1;
    repeat (10) cycle();
    io_output = 0; cycle();
    check("held_head", out_data, 8'h55);
    out_ready = 1; cycle(); out_ready = 0;
    check("held_one_entry", out_valid, 1'b0);

    // Read path
    in_valid = 1; in_data = 8'hA5; cycle();
    in_data = 8'h5A; cycle();
    in_valid = 0;
    rd_port(0); check("rd_first", io_rdata, 8'hA5);
    rd_port(0); check("rd_second", io_rdata, 8'h5A);
    rd_port(0); check("rd_empty", io_rdata, 8'h00);
    check("rd_underflow", rx_underflow, 1'b1);

    rst = 1; cycle(); rst = 0; cycle();

    // Overflow and status
    for (int i = 0; i < 9; i++) wr_byte(0, 8'h10 + 8'(i));
    check("ovf_set", tx_overflow, 1'b1);
    io_sel = 1; io_reading = 1; cycle();
    check("status_0A", io_rdata, 8'h0A);
    io_reading = 0; cycle();
    check("ovf_cleared", tx_overflow, 1'b0);
    io_sel = 0; out_ready = 1;
    repeat (10) cycle();
    out_ready = 0;

    // RX wrap with concurrent reads every third cycle
    pushed = 0; io_sel = 0;
    for (int c = 0; c < 80; c++) begin
      in_valid   = (pushed < 20);
      in_data    = 8'hC0 + 8'(pushed);
      io_reading = (c % 3 == 0);
      accepted   = in_valid && (rxq.size() < DEPTH);
      cycle();
      if (accepted) pushed++;
    end
    in_valid = 0; io_reading = 0; cycle();

    // Reset with the write strobe held high
    wr_byte(0, 8'h01); wr_byte(0, 8'h02); wr_byte(0, 8'h03);
    io_wdata = 8'h77; io_output = 1; rst = 1; cycle();
    rst = 0; cycle(); cycle();
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_underflow", rx_underflow, 1'b0);
    io_output = 0; cycle();
    wr_byte(0, 8'h99);
    check("post_rst_write", out_data, 8'h99);
    out_ready = 1; cycle(); cycle(); out_ready = 0;

    // Randomized traffic
    repeat (3000) begin
      rst        = ($urandom_range(0, 299) == 0);
      io_sel     = 4'($urandom_range(0, 2));
      io_wdata   = 8'($urandom);
      io_output  = 1'($urandom_range(0, 1));
      io_reading = 1'($urandom_range(0, 1));
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = 8'($urandom);
      out_ready  = ($urandom_range(0, 2) == 0);
      cycle();
    end
    rst = 0; io_output = 0; io_reading = 0; in_valid = 0; out_ready = 0;
    repeat (3) cycle();
    check("rd_scoreboard_drained", 8'(exp_rd.size()), 8'h00);
    check("tx_scoreboard_drained", 8'(exp_tx.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
